fold_fuser: RTL

Receiver at the far end of the spatial encoder's hypervector stream. It accepts one FOLD_WIDTH-bit encoded slice per modality, in the order GSR, ECG, EEG, for each fold. On the EEG slice it forms the bitwise majority of the three slices. It emits the fused fold downstream toward the associative memory on a valid/ready register stage, tagged with its fold index and a last flag.

---
 rtl/fold_fuser_pkg.sv | 16 +
 rtl/fold_fuser_majority3.sv | 13 +
 rtl/fold_fuser.sv | 123 ++++++++++++
 3 files changed

// File: rtl/fold_fuser_pkg.sv
// Shared HDC constants: modality tags, fuser state encoding, full HV width.
package fold_fuser_pkg;

    localparam int unsigned HV_WIDTH = 2000;

    localparam logic [1:0] MOD_GSR = 2'd0;
    localparam logic [1:0] MOD_ECG = 2'd1;
    localparam logic [1:0] MOD_EEG = 2'd2;

    typedef enum logic [1:0] {
        S_WAIT_GSR = 2'd0,
        S_WAIT_ECG = 2'd1,
        S_WAIT_EEG = 2'd2
    } fuser_state_e;

endpackage

// File: rtl/fold_fuser_majority3.sv
// Bitwise 3-input majority; purely combinational, shared by fusing stages.
module hv_majority3 #(
    parameter int unsigned WIDTH = 2000
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] c_i,
    output logic [WIDTH-1:0] maj_o
);

    assign maj_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);

endmodule

// File: rtl/fold_fuser.sv
// Collects GSR/ECG/EEG slices per fold and emits their majority on a
// registered valid/ready stage tagged with a down-counting fold index.
module fold_fuser
    import fold_fuser_pkg::*;
#(
    parameter int unsigned NUM_FOLDS       = 1,
    parameter int unsigned NUM_FOLDS_WIDTH = 1,
    parameter int unsigned FOLD_WIDTH      = HV_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       hvin_valid,
    output logic                       hvin_ready,
    input  logic [FOLD_WIDTH-1:0]      hvin,
    input  logic [1:0]                 modality,
    output logic                       fused_valid,
    input  logic                       fused_ready,
    output logic [FOLD_WIDTH-1:0]      fused_hv,
    output logic [NUM_FOLDS_WIDTH-1:0] fused_fold_idx,
    output logic                       fused_last,
    output logic                       seq_error,
    output logic                       overrun
);

    localparam logic [NUM_FOLDS_WIDTH-1:0] TOP_IDX =
        NUM_FOLDS_WIDTH'(NUM_FOLDS - 1);

    fuser_state_e                 state_q;
    logic [FOLD_WIDTH-1:0]        gsr_buf_q;
    logic [FOLD_WIDTH-1:0]        ecg_buf_q;
    logic [FOLD_WIDTH-1:0]        fused_hv_q;
    logic [FOLD_WIDTH-1:0]        maj;
    logic [NUM_FOLDS_WIDTH-1:0]   fold_idx_q;
    logic [NUM_FOLDS_WIDTH-1:0]   fold_idx_d;
    logic [NUM_FOLDS_WIDTH-1:0]   fused_idx_q;
    logic                         fused_valid_q;
    logic                         fused_last_q;
    logic                         seq_error_q;
    logic                         overrun_q;
    logic [1:0]                   exp_mod;
    logic                         in_fire;
    logic                         out_fire;
    logic                         mod_ok;

    hv_majority3 #(
        .WIDTH (FOLD_WIDTH)
    ) u_maj (
        .a_i   (gsr_buf_q),
        .b_i   (ecg_buf_q),
        .c_i   (hvin),
        .maj_o (maj)
    );

    always_comb begin
        exp_mod = MOD_GSR;
        unique case (state_q)
            S_WAIT_GSR: exp_mod = MOD_GSR;
            S_WAIT_ECG: exp_mod = MOD_ECG;
            S_WAIT_EEG: exp_mod = MOD_EEG;
            default:    exp_mod = MOD_GSR;
        endcase
    end

    // Only the EEG beat needs the output register free; it is the loading beat.
    assign hvin_ready = (state_q != S_WAIT_EEG) || !fused_valid_q || fused_ready;
    assign in_fire    = hvin_valid && hvin_ready;
    assign out_fire   = fused_valid_q && fused_ready;
    assign mod_ok     = (modality == exp_mod);
    assign fold_idx_d = (fold_idx_q == '0) ? TOP_IDX : fold_idx_q - 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_WAIT_GSR;
            fold_idx_q    <= TOP_IDX;
            gsr_buf_q     <= '0;
            ecg_buf_q     <= '0;
            fused_hv_q    <= '0;
            fused_idx_q   <= '0;
            fused_last_q  <= 1'b0;
            fused_valid_q <= 1'b0;
            seq_error_q   <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            if (hvin_valid && !hvin_ready) begin
                overrun_q <= 1'b1;
            end
            if (out_fire) begin
                fused_valid_q <= 1'b0;
            end
            if (in_fire && !mod_ok) begin
                seq_error_q <= 1'b1;
            end else if (in_fire) begin
                unique case (state_q)
                    S_WAIT_GSR: begin
                        gsr_buf_q <= hvin;
                        state_q   <= S_WAIT_ECG;
                    end
                    S_WAIT_ECG: begin
                        ecg_buf_q <= hvin;
                        state_q   <= S_WAIT_EEG;
                    end
                    S_WAIT_EEG: begin
                        fused_hv_q    <= maj;
                        fused_idx_q   <= fold_idx_q;
                        fused_last_q  <= (fold_idx_q == '0);
                        fused_valid_q <= 1'b1;
                        fold_idx_q    <= fold_idx_d;
                        state_q       <= S_WAIT_GSR;
                    end
                    default: state_q <= S_WAIT_GSR;
                endcase
            end
        end
    end

    assign fused_valid    = fused_valid_q;
    assign fused_hv       = fused_hv_q;
    assign fused_fold_idx = fused_idx_q;
    assign fused_last     = fused_last_q;
    assign seq_error      = seq_error_q;
    assign overrun        = overrun_q;

endmodule
